// File: rtl/spw_tx_char_serializer_if.sv
// ----------------------------------------------------------------------------
// spw_tx_char_serializer_if
//   Character-level handshake between the link FSM / TX FIFO and the SpaceWire
//   transmit character serializer.
//
//   fct_req        link FSM -> serializer  request one FCT, held until fct_ack
//   fct_ack        serializer -> link FSM  1-cycle pulse when the FCT is loaded
//   tx_valid       FIFO -> serializer      N-char available
//   tx_is_control  FIFO -> serializer      1 = EOP/EEP (code in tx_data[1:0])
//   tx_data        FIFO -> serializer      data byte or control code
//   tx_ready       serializer -> FIFO      N-char taken when tx_valid & tx_ready
//
//   master: link FSM / FIFO side.  slave: serializer side.
// ----------------------------------------------------------------------------
interface spw_tx_char_serializer_if;
    logic       fct_req;
    logic       fct_ack;
    logic       tx_valid;
    logic       tx_is_control;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output fct_req,
        output tx_valid,
        output tx_is_control,
        output tx_data,
        input  fct_ack,
        input  tx_ready
    );

    modport slave (
        input  fct_req,
        input  tx_valid,
        input  tx_is_control,
        input  tx_data,
        output fct_ack,
        output tx_ready
    );
endinterface

// File: rtl/spw_tx_char_serializer.sv
// ----------------------------------------------------------------------------
// spw_tx_char_serializer
//   SpaceWire transmit character serializer. At each character slot it picks
//   the next character by priority [time-code] > FCT > N-char > NULL, adds odd
//   parity, and shifts it out one bit per tx_bit_en on the Data/Strobe pair.
//
// Ports
//   tx_clk      in   transmit clock, all logic on posedge
//   tx_resetn   in   asynchronous active-low reset
//   tx_enable   in   link FSM permits transmission; low = disconnect
//   tx_bit_en   in   bit-rate strobe, one bit shifted per high cycle
//   tick_in     in   (TX_TIME_CODE_EN only) latch time_in for sending
//   time_in     in   (TX_TIME_CODE_EN only) time-code value
//   chr_if      slave modport of spw_tx_char_serializer_if (FCT / N-char)
//   tx_dout     out  registered SpaceWire Data line
//   tx_sout     out  registered SpaceWire Strobe line
//
// Configuration
//   TX_TIME_CODE_EN  define to add time-code transmission (ESC + data char).
// ----------------------------------------------------------------------------
module spw_tx_char_serializer (
    input  logic                      tx_clk,
    input  logic                      tx_resetn,
    input  logic                      tx_enable,
    input  logic                      tx_bit_en,
`ifdef TX_TIME_CODE_EN
    input  logic                      tick_in,
    input  logic [7:0]                time_in,
`endif
    spw_tx_char_serializer_if.slave   chr_if,
    output logic                      tx_dout,
    output logic                      tx_sout
);

    localparam logic [1:0] CODE_FCT = 2'd0;
    localparam logic [1:0] CODE_ESC = 2'd3;

    typedef enum logic {DISABLED, SEND} state_t;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [3:0] term_cnt;
    logic [8:0] shreg;
    logic       acc;
    logic       null_fct;     // FCT half of a NULL still owed

`ifdef TX_TIME_CODE_EN
    logic       tc_pend;
    logic       tc_dat_pend;  // data half of a time-code still owed
    logic [7:0] time_reg;
    logic [7:0] tc_byte;
    logic       tc_esc_sel;
`endif

    logic       slot;
    logic       fct_win;
    logic       nchar_win;
    logic       start_null;
    logic       ld_ctrl;
    logic [1:0] ld_code;
    logic [7:0] ld_byte;
    logic       ld_par;
    logic       ld_acc;
    logic [8:0] ld_shreg;
    logic [3:0] ld_term;
    logic       nxt_bit;

    // bit_cnt == term_cnt also holds after disable (both zero), so the first
    // tx_bit_en in SEND is a slot without a separate "first char" flag.
    assign slot = (state == SEND) && tx_enable && tx_bit_en && (bit_cnt == term_cnt);

    // Character selection; atomic second halves outrank new requests.
    always_comb begin
        fct_win    = 1'b0;
        nchar_win  = 1'b0;
        start_null = 1'b0;
        ld_ctrl    = 1'b1;
        ld_code    = CODE_ESC;
        ld_byte    = '0;
`ifdef TX_TIME_CODE_EN
        tc_esc_sel = 1'b0;
`endif
        if (null_fct) begin
            ld_code = CODE_FCT;
        end
`ifdef TX_TIME_CODE_EN
        else if (tc_dat_pend) begin
            ld_ctrl = 1'b0;
            ld_byte = tc_byte;
        end
        else if (tc_pend) begin
            tc_esc_sel = 1'b1;
        end
`endif
        else if (chr_if.fct_req) begin
            ld_code = CODE_FCT;
            fct_win = 1'b1;
        end
        else if (chr_if.tx_valid) begin
            nchar_win = 1'b1;
            ld_ctrl   = chr_if.tx_is_control;
            ld_code   = chr_if.tx_data[1:0];
            ld_byte   = chr_if.tx_data;
        end
        else begin
            start_null = 1'b1;
        end
    end

    // Shift register holds the bits after P, next-out at bit 0.
    always_comb begin
        ld_par = 1'b1 ^ acc ^ ld_ctrl;
        if (ld_ctrl) begin
            ld_shreg = {6'b0, ld_code[0], ld_code[1], 1'b1};
            ld_acc   = ^ld_code;
            ld_term  = 4'd3;
        end else begin
            ld_shreg = {ld_byte, 1'b0};
            ld_acc   = ^ld_byte;
            ld_term  = 4'd9;
        end
        nxt_bit = slot ? ld_par : shreg[0];
    end

    assign chr_if.tx_ready = slot && nchar_win;

    always_ff @(posedge tx_clk or negedge tx_resetn) begin
        if (!tx_resetn) begin
            state          <= DISABLED;
            tx_dout        <= 1'b0;
            tx_sout        <= 1'b0;
            chr_if.fct_ack <= 1'b0;
            acc            <= 1'b0;
            shreg          <= '0;
            bit_cnt        <= '0;
            term_cnt       <= '0;
            null_fct       <= 1'b0;
`ifdef TX_TIME_CODE_EN
            tc_pend        <= 1'b0;
            tc_dat_pend    <= 1'b0;
            time_reg       <= '0;
            tc_byte        <= '0;
`endif
        end else begin
            chr_if.fct_ack <= 1'b0;
`ifdef TX_TIME_CODE_EN
            // A tick coinciding with an ESC load re-arms for a new time-code.
            if (tick_in) begin
                tc_pend  <= 1'b1;
                time_reg <= time_in;
            end else if (slot && tc_esc_sel) begin
                tc_pend  <= 1'b0;
            end
`endif
            if (!tx_enable) begin
                state    <= DISABLED;
                tx_dout  <= 1'b0;
                tx_sout  <= 1'b0;
                acc      <= 1'b0;
                shreg    <= '0;
                bit_cnt  <= '0;
                term_cnt <= '0;
                null_fct <= 1'b0;
`ifdef TX_TIME_CODE_EN
                tc_dat_pend <= 1'b0;
`endif
            end else begin
                case (state)
                    DISABLED: state <= SEND;
                    SEND: begin
                        if (tx_bit_en) begin
                            tx_dout <= nxt_bit;
                            if (nxt_bit == tx_dout)
                                tx_sout <= ~tx_sout;
                            if (slot) begin
                                shreg          <= ld_shreg;
                                bit_cnt        <= '0;
                                term_cnt       <= ld_term;
                                acc            <= ld_acc;
                                null_fct       <= start_null;
                                chr_if.fct_ack <= fct_win;
`ifdef TX_TIME_CODE_EN
                                tc_dat_pend    <= tc_esc_sel;
                                if (tc_esc_sel)
                                    tc_byte <= time_reg;
`endif
                            end else begin
                                shreg   <= {1'b0, shreg[8:1]};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    default: state <= DISABLED;
                endcase
            end
        end
    end

endmodule
